// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and writeback stage: load extraction, writeback mux,
// register-file write port, sticky misaligned-load flag and retired-instruction counter.
module mem_wb_stage #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             flush,
    input  logic             mem_valid,
    input  logic             mem_reg_write,
    input  logic [1:0]       mem_wb_sel,
    input  logic [2:0]       mem_load_type,
    input  logic [1:0]       mem_addr_low,
    input  logic [31:0]      mem_read_data,
    input  logic [31:0]      mem_alu_result,
    input  logic [31:0]      mem_link_addr,
    input  logic [4:0]       mem_write_reg,
    output logic             wr_enable3,
    output logic [4:0]       write_addr3,
    output logic [31:0]      write_data3,
    output logic             wb_valid,
    output logic             misaligned,
    output logic [CNT_W-1:0] retired_count
);

    localparam logic [2:0] LdLw  = 3'b000;
    localparam logic [2:0] LdLb  = 3'b001;
    localparam logic [2:0] LdLbu = 3'b010;
    localparam logic [2:0] LdLh  = 3'b011;
    localparam logic [2:0] LdLhu = 3'b100;

    logic [7:0]       byte_sel;
    logic [15:0]      half_sel;
    logic [31:0]      load_data;
    logic             mis_load;
    logic [31:0]      wb_data_d;
    logic             wr_en_d;
    logic             capture;

    logic             wr_en_q;
    logic [4:0]       addr_q;
    logic [31:0]      data_q;
    logic             valid_q;
    logic             mis_q;
    logic [CNT_W-1:0] cnt_q;

    always_comb begin
        unique case (mem_addr_low)
            2'd0:    byte_sel = mem_read_data[7:0];
            2'd1:    byte_sel = mem_read_data[15:8];
            2'd2:    byte_sel = mem_read_data[23:16];
            default: byte_sel = mem_read_data[31:24];
        endcase
        half_sel = mem_addr_low[1] ? mem_read_data[31:16] : mem_read_data[15:0];

        case (mem_load_type)
            LdLb:    load_data = {{24{byte_sel[7]}}, byte_sel};
            LdLbu:   load_data = {24'd0, byte_sel};
            LdLh:    load_data = {{16{half_sel[15]}}, half_sel};
            LdLhu:   load_data = {16'd0, half_sel};
            default: load_data = mem_read_data;
        endcase

        // Byte loads can never be misaligned; unknown types behave as lw.
        mis_load = 1'b0;
        if (mem_wb_sel == 2'b01) begin
            case (mem_load_type)
                LdLb, LdLbu: mis_load = 1'b0;
                LdLh, LdLhu: mis_load = mem_addr_low[0];
                default:     mis_load = (mem_addr_low != 2'd0);
            endcase
        end

        case (mem_wb_sel)
            2'b01:   wb_data_d = load_data;
            2'b10:   wb_data_d = mem_link_addr;
            default: wb_data_d = mem_alu_result;
        endcase

        wr_en_d = mem_valid & mem_reg_write & ~mis_load & (mem_write_reg != 5'd0);
        capture = ~flush & ~stall;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en_q <= 1'b0;
            addr_q  <= 5'd0;
            data_q  <= 32'd0;
            valid_q <= 1'b0;
            mis_q   <= 1'b0;
            cnt_q   <= '0;
        end else if (flush) begin
            wr_en_q <= 1'b0;
            addr_q  <= 5'd0;
            data_q  <= 32'd0;
            valid_q <= 1'b0;
        end else if (capture) begin
            wr_en_q <= wr_en_d;
            addr_q  <= mem_write_reg;
            data_q  <= wb_data_d;
            valid_q <= mem_valid;
            mis_q   <= mis_q | (mem_valid & mis_load);
            // Retirement is counted once, when the instruction enters WB.
            if (mem_valid && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign wr_enable3    = wr_en_q;
    assign write_addr3   = addr_q;
    assign write_data3   = data_q;
    assign wb_valid      = valid_q;
    assign misaligned    = mis_q;
    assign retired_count = cnt_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: scoreboard of expected WB outputs, checked
// one cycle after each MEM-side stimulus, on a 32-bit and a 4-bit counter instance.
module tb_mem_wb_stage;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic        mem_valid;
    logic        mem_reg_write;
    logic [1:0]  mem_wb_sel;
    logic [2:0]  mem_load_type;
    logic [1:0]  mem_addr_low;
    logic [31:0] mem_read_data;
    logic [31:0] mem_alu_result;
    logic [31:0] mem_link_addr;
    logic [4:0]  mem_write_reg;

    logic        wr_enable3, wr_enable3_s;
    logic [4:0]  write_addr3, write_addr3_s;
    logic [31:0] write_data3, write_data3_s;
    logic        wb_valid, wb_valid_s;
    logic        misaligned, misaligned_s;
    logic [31:0] retired_count;
    logic [3:0]  retired_count_s;

    mem_wb_stage #(.CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .mem_valid(mem_valid), .mem_reg_write(mem_reg_write), .mem_wb_sel(mem_wb_sel),
        .mem_load_type(mem_load_type), .mem_addr_low(mem_addr_low),
        .mem_read_data(mem_read_data), .mem_alu_result(mem_alu_result),
        .mem_link_addr(mem_link_addr), .mem_write_reg(mem_write_reg),
        .wr_enable3(wr_enable3), .write_addr3(write_addr3), .write_data3(write_data3),
        .wb_valid(wb_valid), .misaligned(misaligned), .retired_count(retired_count)
    );

    mem_wb_stage #(.CNT_W(4)) dut_small (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .mem_valid(mem_valid), .mem_reg_write(mem_reg_write), .mem_wb_sel(mem_wb_sel),
        .mem_load_type(mem_load_type), .mem_addr_low(mem_addr_low),
        .mem_read_data(mem_read_data), .mem_alu_result(mem_alu_result),
        .mem_link_addr(mem_link_addr), .mem_write_reg(mem_write_reg),
        .wr_enable3(wr_enable3_s), .write_addr3(write_addr3_s), .write_data3(write_data3_s),
        .wb_valid(wb_valid_s), .misaligned(misaligned_s), .retired_count(retired_count_s)
    );

    typedef struct {
        logic        en;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        chk_data;
        logic        valid;
        logic        mis;
        logic [31:0] cnt;
        logic [3:0]  cnt4;
    } exp_t;

    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_cnt = 0;
    logic [3:0]  exp_cnt4 = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one MEM-stage input set, push the expected WB state, then check it after the edge.
    task automatic step(input string tag, input logic v, input logic rw, input logic [1:0] sel,
                        input logic [2:0] lt, input logic [1:0] al, input logic [31:0] rd,
                        input logic [31:0] alu, input logic [31:0] link, input logic [4:0] wr,
                        input logic st, input logic fl, input logic e_en, input logic [4:0] e_addr,
                        input logic [31:0] e_data, input logic e_chk, input logic e_v,
                        input logic e_mis);
        exp_t e;
        exp_t o;
        mem_valid = v; mem_reg_write = rw; mem_wb_sel = sel; mem_load_type = lt;
        mem_addr_low = al; mem_read_data = rd; mem_alu_result = alu; mem_link_addr = link;
        mem_write_reg = wr; stall = st; flush = fl;
        if (v && !st && !fl) begin
            exp_cnt = exp_cnt + 1;
            if (exp_cnt4 != 4'hF) exp_cnt4 = exp_cnt4 + 1;
        end
        e = '{en: e_en, addr: e_addr, data: e_data, chk_data: e_chk, valid: e_v, mis: e_mis,
              cnt: exp_cnt, cnt4: exp_cnt4};
        sb.push_back(e);
        @(posedge clk);
        #1;
        o = sb.pop_front();
        chk({tag, ".en"}, {31'd0, wr_enable3}, {31'd0, o.en});
        chk({tag, ".addr"}, {27'd0, write_addr3}, {27'd0, o.addr});
        if (o.chk_data) chk({tag, ".data"}, write_data3, o.data);
        chk({tag, ".valid"}, {31'd0, wb_valid}, {31'd0, o.valid});
        chk({tag, ".mis"}, {31'd0, misaligned}, {31'd0, o.mis});
        chk({tag, ".cnt"}, retired_count, o.cnt);
        chk({tag, ".cnt4"}, {28'd0, retired_count_s}, {28'd0, o.cnt4});
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".en"}, {31'd0, wr_enable3}, 32'd0);
        chk({tag, ".addr"}, {27'd0, write_addr3}, 32'd0);
        chk({tag, ".data"}, write_data3, 32'd0);
        chk({tag, ".valid"}, {31'd0, wb_valid}, 32'd0);
        chk({tag, ".mis"}, {31'd0, misaligned}, 32'd0);
        chk({tag, ".cnt"}, retired_count, 32'd0);
        chk({tag, ".cnt4"}, {28'd0, retired_count_s}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0; mem_valid = 1'b0; mem_reg_write = 1'b0;
        mem_wb_sel = 2'b00; mem_load_type = 3'b000; mem_addr_low = 2'd0;
        mem_read_data = 32'd0; mem_alu_result = 32'd0; mem_link_addr = 32'd0;
        mem_write_reg = 5'd0;
        #12;
        chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        //   tag      v  rw sel    lt    al  rd            alu           link          wr  st fl  en a   data      chk v mis
        step("lw",    1, 1, 2'b01, 3'd0, 0, 32'h8899AABB, 32'h0,        32'h0,        5,  0, 0, 1, 5,  32'h8899AABB, 1, 1, 0);
        step("lb",    1, 1, 2'b01, 3'd1, 3, 32'h80FF7F01, 32'h0,        32'h0,        6,  0, 0, 1, 6,  32'hFFFFFF80, 1, 1, 0);
        step("lbu",   1, 1, 2'b01, 3'd2, 3, 32'h80FF7F01, 32'h0,        32'h0,        7,  0, 0, 1, 7,  32'h00000080, 1, 1, 0);
        step("lh",    1, 1, 2'b01, 3'd3, 2, 32'h80FF7F01, 32'h0,        32'h0,        8,  0, 0, 1, 8,  32'hFFFF80FF, 1, 1, 0);
        step("lhu",   1, 1, 2'b01, 3'd4, 0, 32'h80FF7F01, 32'h0,        32'h0,        9,  0, 0, 1, 9,  32'h00007F01, 1, 1, 0);
        step("lb1",   1, 1, 2'b01, 3'd1, 1, 32'h80FF7F01, 32'h0,        32'h0,        2,  0, 0, 1, 2,  32'h0000007F, 1, 1, 0);
        step("aluoff",1, 1, 2'b00, 3'd0, 2, 32'h0,        32'h00005555, 32'h0,        3,  0, 0, 1, 3,  32'h00005555, 1, 1, 0);
        step("nowr",  1, 0, 2'b00, 3'd0, 0, 32'h0,        32'h00000042, 32'h0,        4,  0, 0, 0, 4,  32'h00000042, 1, 1, 0);
        step("lhmis", 1, 1, 2'b01, 3'd3, 1, 32'h80FF7F01, 32'h0,        32'h0,        10, 0, 0, 0, 10, 32'h0,        0, 1, 1);
        for (int i = 0; i < 10; i++) begin
            step("idle", 0, 0, 2'b00, 3'd0, 0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0, 0, 32'h0, 1, 0, 1);
        end
        step("r0",    1, 1, 2'b00, 3'd0, 0, 32'h0,        32'h00001234, 32'h0,        0,  0, 0, 0, 0,  32'h00001234, 1, 1, 1);
        step("jal",   1, 1, 2'b10, 3'd0, 0, 32'h0,        32'h0,        32'h00400010, 31, 0, 0, 1, 31, 32'h00400010, 1, 1, 1);
        step("rsvd",  1, 1, 2'b11, 3'd0, 0, 32'h0,        32'hDEADBEEF, 32'h11111111, 3,  0, 0, 1, 3,  32'hDEADBEEF, 1, 1, 1);

        // Stall for three cycles, flushing on the second.
        step("pre",   1, 1, 2'b00, 3'd0, 0, 32'h0,        32'h0000CAFE, 32'h0,        12, 0, 0, 1, 12, 32'h0000CAFE, 1, 1, 1);
        step("stl1",  1, 1, 2'b00, 3'd0, 0, 32'h0,        32'h0000BEEF, 32'h0,        13, 1, 0, 1, 12, 32'h0000CAFE, 1, 1, 1);
        step("stl2f", 1, 1, 2'b00, 3'd0, 0, 32'h0,        32'h0000BEEF, 32'h0,        13, 1, 1, 0, 0,  32'h0,        1, 0, 1);
        step("stl3",  1, 1, 2'b00, 3'd0, 0, 32'h0,        32'h0000BEEF, 32'h0,        13, 1, 0, 0, 0,  32'h0,        1, 0, 1);

        for (int i = 0; i < 20; i++) begin
            step("ret", 1, 1, 2'b00, 3'd0, 0, 32'h0, 32'h100 + 32'(i), 32'h0, 5'(i % 31 + 1),
                 0, 0, 1, 5'(i % 31 + 1), 32'h100 + 32'(i), 1, 1, 1);
        end
        chk("sat4", {28'd0, retired_count_s}, 32'd15);

        // Asynchronous reset between edges clears everything immediately.
        mem_valid = 1'b1; mem_reg_write = 1'b1; mem_wb_sel = 2'b00; mem_alu_result = 32'h77;
        mem_write_reg = 5'd9; stall = 1'b0; flush = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("asyncrst");
        exp_cnt = 0;
        exp_cnt4 = 0;
        @(negedge clk);
        rst_n = 1'b1;

        step("lwmis", 1, 1, 2'b01, 3'd0, 2, 32'h12345678, 32'h0,        32'h0,        11, 0, 0, 0, 11, 32'h0,        0, 1, 1);
        step("lhuok", 1, 1, 2'b01, 3'd4, 2, 32'h12345678, 32'h0,        32'h0,        14, 0, 0, 1, 14, 32'h00001234, 1, 1, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
